// File: rtl/paddle_controller.sv
// Player paddle controller: synchronises and debounces the up/down buttons, then moves
// a PADDLE_LEN-cell paddle on game ticks with press-and-hold auto-repeat, clamped to the playfield.

module paddle_debounce #(
   parameter int DEB_CYCLES = 3
) (
   input  logic clk,
   input  logic rst,
   input  logic raw,
   output logic level
);
   localparam int CW = $clog2(DEB_CYCLES) + 1;

   logic [1:0]    sync;
   logic [CW-1:0] cnt;

   // cnt is the length of the current run of synced samples that disagree with level
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync  <= '0;
         cnt   <= '0;
         level <= 1'b0;
      end else begin
         sync <= {sync[0], raw};
         if (sync[1] == level) begin
            cnt <= '0;
         end else if (cnt == CW'(DEB_CYCLES - 1)) begin
            level <= sync[1];
            cnt   <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end
endmodule

module paddle_controller #(
   parameter int WIDTH        = 8,
   parameter int BIT_WIDTH    = 3,
   parameter int PADDLE_LEN   = 3,
   parameter int DEB_CYCLES   = 3,
   parameter int REPEAT_TICKS = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 tick,
   input  logic                 btn_up,
   input  logic                 btn_down,
   input  logic                 freeze,
   output logic [BIT_WIDTH-1:0] state_left,
   output logic [BIT_WIDTH-1:0] state_right,
   output logic                 at_top,
   output logic                 at_bottom,
   output logic                 moved
);
   localparam int RW = (REPEAT_TICKS > 1) ? $clog2(REPEAT_TICKS) : 1;
   localparam logic [BIT_WIDTH-1:0] LEFT_MAX = BIT_WIDTH'(WIDTH - PADDLE_LEN);
   localparam logic [BIT_WIDTH-1:0] LEFT_RST = BIT_WIDTH'((WIDTH - PADDLE_LEN) / 2);
   localparam logic [RW-1:0]        RELOAD   = RW'(REPEAT_TICKS - 1);

   typedef enum logic {IDLE, HOLD} state_t;

   logic [1:0]    raw_btn;
   logic [1:0]    deb;
   logic          cmd_up, cmd_down, same_dir;
   logic          step_en, step_dn;
   state_t        state;
   logic          dir_down;
   logic [RW-1:0] repeat_cnt;

   assign raw_btn = {btn_down, btn_up};

   for (genvar i = 0; i < 2; i++) begin : g_deb
      paddle_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
         .clk  (clk),
         .rst  (rst),
         .raw  (raw_btn[i]),
         .level(deb[i])
      );
   end

   assign cmd_up   = deb[0] & ~deb[1];
   assign cmd_down = deb[1] & ~deb[0];
   assign same_dir = dir_down ? cmd_down : cmd_up;

   always_comb begin
      step_en = 1'b0;
      step_dn = cmd_down;
      if (!freeze && tick) begin
         unique case (state)
            IDLE: step_en = cmd_up | cmd_down;
            HOLD: step_en = same_dir && (repeat_cnt == '0);
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         dir_down   <= 1'b0;
         repeat_cnt <= '0;
         state_left <= LEFT_RST;
         moved      <= 1'b0;
      end else begin
         moved <= 1'b0;
         if (freeze) begin
            state      <= IDLE;
            dir_down   <= 1'b0;
            repeat_cnt <= '0;
         end else if (tick) begin
            unique case (state)
               IDLE: if (cmd_up | cmd_down) begin
                  state      <= HOLD;
                  dir_down   <= cmd_down;
                  repeat_cnt <= RELOAD;
               end
               HOLD: if (!same_dir) begin
                  // release or reversal: the new direction steps on a later tick
                  state      <= IDLE;
                  repeat_cnt <= '0;
               end else if (repeat_cnt == '0) begin
                  repeat_cnt <= RELOAD;
               end else begin
                  repeat_cnt <= repeat_cnt - 1'b1;
               end
            endcase
         end
         // clamped steps keep the repeat cadence but leave position and moved alone
         if (step_en && step_dn && state_left != LEFT_MAX) begin
            state_left <= state_left + 1'b1;
            moved      <= 1'b1;
         end else if (step_en && !step_dn && state_left != '0) begin
            state_left <= state_left - 1'b1;
            moved      <= 1'b1;
         end
      end
   end

   assign state_right = state_left + BIT_WIDTH'(PADDLE_LEN - 1);
   assign at_top      = (state_left == '0);
   assign at_bottom   = (state_left == LEFT_MAX);
endmodule

// File: tb/tb_paddle_controller.sv
// Bench for paddle_controller: directed segment table plus randomized buttons/ticks/freeze
// compared every clk against a window-and-tick-count reference model.

module tb_paddle_controller;
   localparam int W   = 8;
   localparam int BW  = 3;
   localparam int P   = 3;
   localparam int DEB = 3;
   localparam int REP = 2;

   logic          clk = 1'b0, rst = 1'b1, tick = 1'b0;
   logic          btn_up = 1'b0, btn_down = 1'b0, freeze = 1'b0;
   logic [BW-1:0] state_left, state_right;
   logic          at_top, at_bottom, moved;

   int total = 0;
   int bad   = 0;

   paddle_controller #(.WIDTH(W), .BIT_WIDTH(BW), .PADDLE_LEN(P),
                       .DEB_CYCLES(DEB), .REPEAT_TICKS(REP)) dut (
      .clk(clk), .rst(rst), .tick(tick), .btn_up(btn_up), .btn_down(btn_down),
      .freeze(freeze), .state_left(state_left), .state_right(state_right),
      .at_top(at_top), .at_bottom(at_bottom), .moved(moved)
   );

   always #5 clk = ~clk;

   // reference model: raw-sample history window, hold direction and tick count
   int m_left;
   bit m_moved;
   int hdir;
   int hn;
   bit du, dd;
   bit hu[DEB+2];
   bit hd[DEB+2];

   function automatic void m_reset();
      m_left  = (W - P) / 2;
      m_moved = 0;
      hdir    = 0;
      hn      = 0;
      du      = 0;
      dd      = 0;
      for (int i = 0; i < DEB + 2; i++) begin
         hu[i] = 0;
         hd[i] = 0;
      end
   endfunction

   function automatic void m_edge(bit up, bit dn, bit tk, bit frz);
      int cmd;
      int nl;
      bit step;
      bit flip_u, flip_d;
      cmd  = (du && !dd) ? -1 : (dd && !du) ? 1 : 0;
      nl   = m_left;
      step = 0;
      if (frz) begin
         hdir = 0;
         hn   = 0;
      end else if (tk) begin
         if (hdir == 0) begin
            if (cmd != 0) begin
               step = 1;
               hdir = cmd;
               hn   = 1;
            end
         end else if (cmd == hdir) begin
            if (hn % REP == 0) step = 1;
            hn++;
         end else begin
            hdir = 0;
            hn   = 0;
         end
         if (step) begin
            nl = m_left + hdir;
            if (nl < 0) nl = 0;
            if (nl > W - P) nl = W - P;
         end
      end
      m_moved = (nl != m_left);
      m_left  = nl;
      for (int i = DEB + 1; i > 0; i--) begin
         hu[i] = hu[i-1];
         hd[i] = hd[i-1];
      end
      hu[0] = up;
      hd[0] = dn;
      // accept a new level once the last DEB synced samples all disagree with it
      flip_u = 1;
      flip_d = 1;
      for (int j = 2; j < DEB + 2; j++) begin
         if (hu[j] == du) flip_u = 0;
         if (hd[j] == dd) flip_d = 0;
      end
      if (flip_u) du = ~du;
      if (flip_d) dd = ~dd;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk_model();
      chk("model_left", int'(state_left), m_left);
      chk("model_right", int'(state_right), m_left + P - 1);
      chk("model_at_top", int'(at_top), int'(m_left == 0));
      chk("model_at_bottom", int'(at_bottom), int'(m_left + P - 1 == W - 1));
      chk("model_moved", int'(moved), int'(m_moved));
   endtask

   // called at a negedge; returns at the next negedge
   task automatic cyc(input bit up, input bit dn, input bit tk, input bit frz);
      btn_up   = up;
      btn_down = dn;
      tick     = tk;
      freeze   = frz;
      @(posedge clk);
      m_edge(up, dn, tk, frz);
      #1;
      chk_model();
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst  = 1'b1;
      tick = 1'b0;
      #1;
      m_reset();
      chk("rst_left", int'(state_left), 2);
      chk("rst_right", int'(state_right), 4);
      chk("rst_moved", int'(moved), 0);
      chk("rst_at_top", int'(at_top), 0);
      chk("rst_at_bottom", int'(at_bottom), 0);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   typedef struct {
      bit r;
      bit up;
      bit dn;
      bit frz;
      int n;
      bit tk;
      int left;
      bit mv;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(bit r, bit up, bit dn, bit frz, int n, bit tk, int left, bit mv);
      vec_t v;
      v.r = r; v.up = up; v.dn = dn; v.frz = frz;
      v.n = n; v.tk = tk; v.left = left; v.mv = mv;
      return v;
   endfunction

   initial begin
      bit u, d;
      m_reset();
      // tap
      vecs.push_back(mk(1, 1, 0, 0, 6, 1, 1, 1));
      vecs.push_back(mk(0, 1, 0, 0, 4, 0, 1, 0));
      vecs.push_back(mk(0, 0, 0, 0, 8, 1, 1, 0));
      // hold down: steps on ticks 1,3,5 then clamps
      vecs.push_back(mk(1, 0, 1, 0, 6, 1, 3, 1));
      vecs.push_back(mk(0, 0, 1, 0, 2, 1, 3, 0));
      vecs.push_back(mk(0, 0, 1, 0, 2, 1, 4, 1));
      vecs.push_back(mk(0, 0, 1, 0, 2, 1, 4, 0));
      vecs.push_back(mk(0, 0, 1, 0, 2, 1, 5, 1));
      vecs.push_back(mk(0, 0, 1, 0, 2, 1, 5, 0));
      vecs.push_back(mk(0, 0, 1, 0, 2, 1, 5, 0));
      vecs.push_back(mk(0, 0, 1, 0, 2, 1, 5, 0));
      // glitch shorter than debounce
      vecs.push_back(mk(1, 1, 0, 0, 2, 0, 2, 0));
      vecs.push_back(mk(0, 0, 0, 0, 6, 1, 2, 0));
      vecs.push_back(mk(0, 0, 0, 0, 2, 1, 2, 0));
      // both buttons, then release down, then run into the top
      vecs.push_back(mk(1, 1, 1, 0, 6, 1, 2, 0));
      vecs.push_back(mk(0, 1, 1, 0, 2, 1, 2, 0));
      vecs.push_back(mk(0, 1, 1, 0, 2, 1, 2, 0));
      vecs.push_back(mk(0, 1, 1, 0, 2, 1, 2, 0));
      vecs.push_back(mk(0, 1, 0, 0, 5, 1, 2, 0));
      vecs.push_back(mk(0, 1, 0, 0, 1, 1, 1, 1));
      vecs.push_back(mk(0, 1, 0, 0, 2, 1, 1, 0));
      vecs.push_back(mk(0, 1, 0, 0, 2, 1, 0, 1));
      vecs.push_back(mk(0, 1, 0, 0, 2, 1, 0, 0));
      vecs.push_back(mk(0, 1, 0, 0, 2, 1, 0, 0));
      // freeze, resume, reset mid-hold, re-press
      vecs.push_back(mk(1, 0, 1, 0, 6, 1, 3, 1));
      vecs.push_back(mk(0, 0, 1, 1, 2, 1, 3, 0));
      vecs.push_back(mk(0, 0, 1, 1, 2, 1, 3, 0));
      vecs.push_back(mk(0, 0, 1, 1, 2, 1, 3, 0));
      vecs.push_back(mk(0, 0, 1, 0, 2, 1, 4, 1));
      vecs.push_back(mk(0, 0, 1, 0, 2, 1, 4, 0));
      vecs.push_back(mk(1, 0, 1, 0, 4, 1, 2, 0));
      vecs.push_back(mk(0, 0, 1, 0, 2, 1, 3, 1));

      repeat (2) @(posedge clk);
      @(negedge clk);
      do_reset();

      foreach (vecs[i]) begin
         if (vecs[i].r) do_reset();
         for (int c = 0; c < vecs[i].n; c++)
            cyc(vecs[i].up, vecs[i].dn, (c == vecs[i].n - 1) ? vecs[i].tk : 1'b0, vecs[i].frz);
         chk("vec_left", int'(state_left), vecs[i].left);
         chk("vec_right", int'(state_right), vecs[i].left + P - 1);
         chk("vec_moved", int'(moved), int'(vecs[i].mv));
         chk("vec_at_top", int'(at_top), int'(vecs[i].left == 0));
         chk("vec_at_bottom", int'(at_bottom), int'(vecs[i].left == W - P));
      end

      u = 0;
      d = 0;
      repeat (3000) begin
         if ($urandom_range(0, 9) == 0) u = ~u;
         if ($urandom_range(0, 9) == 0) d = ~d;
         if ($urandom_range(0, 399) == 0) do_reset();
         else cyc(u, d, $urandom_range(0, 2) == 0, $urandom_range(0, 29) == 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
